// File: rtl/io_timer.sv
// io_timer: 8-bit prescaled timer with reload, compare match and level irq on the IO bus
//   clk          system clock
//   reset        asynchronous active-low reset
//   pause        core stall: freezes io_readdata and blocks register writes
//   io_readaddr  {bank, offset} read address; io_readdata valid one cycle later
//   io_writeaddr {bank, offset} write address, io_writedata data, io_write_en strobe
//   irq          (OVF & OVF_IE) | (CMP & CMP_IE)
module io_timer #(
  parameter logic [1:0] BANK     = 2'd0,
  parameter int         PS_WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  input  logic [4:0] io_readaddr,
  output logic [7:0] io_readdata,
  input  logic [4:0] io_writeaddr,
  input  logic [7:0] io_writedata,
  input  logic       io_write_en,
  output logic       irq
);
  logic                r_en, r_oneshot, r_ovf_ie, r_cmp_ie, r_ovf, r_cmpf;
  logic [2:0]          r_ps;
  logic [7:0]          r_count, r_reload, r_cmp, r_rdata;
  logic [PS_WIDTH-1:0] r_pre;
  logic                w_we, w_wcon, w_wcnt, w_wrel, w_wcmp, w_wstat;
  logic                w_tick, w_adv, w_wrap, w_ovf_set, w_cmp_set;
  logic [PS_WIDTH-1:0] w_mask;
  logic [7:0]          w_next, w_rd;
  assign w_we    = io_write_en && !pause && io_writeaddr[4:3] == BANK;
  assign w_wcon  = w_we && io_writeaddr[2:0] == 3'd0;
  assign w_wcnt  = w_we && io_writeaddr[2:0] == 3'd1;
  assign w_wrel  = w_we && io_writeaddr[2:0] == 3'd2;
  assign w_wcmp  = w_we && io_writeaddr[2:0] == 3'd3;
  assign w_wstat = w_we && io_writeaddr[2:0] == 3'd4;
  // low PS prescaler bits all ones; an empty mask (PS=0) ticks every cycle
  assign w_mask    = ~({PS_WIDTH{1'b1}} << r_ps);
  assign w_tick    = r_en && (r_pre & w_mask) == w_mask;
  // a CPU write to TCOUNT swallows a coincident tick entirely
  assign w_adv     = w_tick && !w_wcnt;
  assign w_wrap    = r_count == 8'hFF;
  assign w_next    = w_wrap ? r_reload : r_count + 8'd1;
  assign w_ovf_set = w_adv && w_wrap;
  assign w_cmp_set = w_adv && w_next == r_cmp;
  always_comb begin
    w_rd = 8'h00;
    if (io_readaddr[4:3] == BANK)
      w_rd = io_readaddr[2:0] == 3'd0 ? {1'b0, r_ps, r_cmp_ie, r_ovf_ie, r_oneshot, r_en} :
             io_readaddr[2:0] == 3'd1 ? r_count :
             io_readaddr[2:0] == 3'd2 ? r_reload :
             io_readaddr[2:0] == 3'd3 ? r_cmp :
             io_readaddr[2:0] == 3'd4 ? {6'd0, r_cmpf, r_ovf} : 8'h00;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {r_en, r_oneshot, r_ovf_ie, r_cmp_ie, r_ovf, r_cmpf} <= '0;
      r_ps     <= '0;
      r_count  <= '0;
      r_reload <= '0;
      r_cmp    <= '0;
      r_rdata  <= '0;
      r_pre    <= '0;
    end else begin
      if (!pause) r_rdata <= w_rd;
      r_pre <= (!r_en || w_wcon || w_wcnt) ? '0 : r_pre + 1'b1;
      if (w_wcon) {r_ps, r_cmp_ie, r_ovf_ie, r_oneshot, r_en} <= io_writedata[6:0];
      else if (w_ovf_set && r_oneshot) r_en <= 1'b0;
      if (w_wcnt) r_count <= io_writedata;
      else if (w_adv) r_count <= w_next;
      if (w_wrel) r_reload <= io_writedata;
      if (w_wcmp) r_cmp <= io_writedata;
      // a flag being set in the same cycle beats the write-1-to-clear
      r_ovf  <= (r_ovf & ~(w_wstat & io_writedata[0])) | w_ovf_set;
      r_cmpf <= (r_cmpf & ~(w_wstat & io_writedata[1])) | w_cmp_set;
    end
  end
  assign io_readdata = r_rdata;
  assign irq         = (r_ovf & r_ovf_ie) | (r_cmpf & r_cmp_ie);
endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: directed stimulus, cycle-level behavioural model and literal checks for io_timer
module tb_io_timer;
  logic       clk = 0, reset = 0, pause = 0, io_write_en = 0, irq;
  logic [4:0] io_readaddr = 0, io_writeaddr = 0;
  logic [7:0] io_writedata = 0, io_readdata, c0;
  int         checks = 0, errors = 0;
  bit         live = 0;
  io_timer #(.BANK(2'd0), .PS_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .pause(pause), .io_readaddr(io_readaddr),
    .io_readdata(io_readdata), .io_writeaddr(io_writeaddr), .io_writedata(io_writedata),
    .io_write_en(io_write_en), .irq(irq));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [7:0] con, cnt, rel, cmp, pre, rd;
    logic       ovf, cf;
  } ms_t;
  ms_t m;
  function automatic logic [7:0] rdv(ms_t s, logic [4:0] a);
    if (a[4:3] != 2'd0) return 8'h00;
    case (a[2:0])
      3'd0: return s.con;
      3'd1: return s.cnt;
      3'd2: return s.rel;
      3'd3: return s.cmp;
      3'd4: return {6'd0, s.cf, s.ovf};
      default: return 8'h00;
    endcase
  endfunction
  function automatic ms_t nxt(ms_t s, logic p, logic we, logic [4:0] wa, logic [7:0] wd, logic [4:0] ra);
    ms_t n;
    bit w, tick, so, sc;
    int off, per;
    logic [7:0] nc;
    n = s;
    w = we && !p && wa[4:3] == 2'd0;
    off = int'(wa[2:0]);
    per = 1 << int'(s.con[6:4]);
    tick = s.con[0] && ((int'(s.pre) + 1) % per == 0);
    so = 0;
    sc = 0;
    if (!p) n.rd = rdv(s, ra);
    n.pre = (!s.con[0] || (w && off <= 1)) ? 8'd0 : s.pre + 8'd1;
    if (tick && !(w && off == 1)) begin
      nc = (s.cnt == 8'hFF) ? s.rel : 8'((int'(s.cnt) + 1) % 256);
      n.cnt = nc;
      so = s.cnt == 8'hFF;
      sc = nc == s.cmp;
      if (so && s.con[1]) n.con[0] = 1'b0;
    end
    if (w && off == 0) n.con = wd & 8'h7F;
    if (w && off == 1) n.cnt = wd;
    if (w && off == 2) n.rel = wd;
    if (w && off == 3) n.cmp = wd;
    n.ovf = (s.ovf && !(w && off == 4 && wd[0])) || so;
    n.cf  = (s.cf && !(w && off == 4 && wd[1])) || sc;
    return n;
  endfunction
  always @(posedge clk or negedge reset)
    if (!reset) m <= '0;
    else m <= nxt(m, pause, io_write_en, io_writeaddr, io_writedata, io_readaddr);
  always @(negedge clk) if (live) begin
    checks += 2;
    if (io_readdata !== m.rd) begin
      errors++;
      $display("FAIL model_rd t=%0t got %h want %h", $time, io_readdata, m.rd);
    end
    if (irq !== ((m.ovf & m.con[2]) | (m.cf & m.con[3]))) begin
      errors++;
      $display("FAIL model_irq t=%0t got %b want %b", $time, irq, (m.ovf & m.con[2]) | (m.cf & m.con[3]));
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    io_writeaddr = a;
    io_writedata = d;
    io_write_en = 1;
    cyc();
    io_write_en = 0;
  endtask
  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  initial begin
    repeat (3) cyc();
    live = 1;
    chk("rst_rd", io_readdata, 8'h00);
    chk("rst_irq", {7'd0, irq}, 8'h00);
    reset = 1;
    wr(5'h02, 8'h5A);
    io_readaddr = 5'h02; cyc(); chk("reload_rd", io_readdata, 8'h5A);
    io_readaddr = 5'h0A; cyc(); chk("bank_mismatch", io_readdata, 8'h00);
    wr(5'h01, 8'hFD); wr(5'h02, 8'h10); wr(5'h00, 8'h05);
    io_readaddr = 5'h01;
    cyc(); chk("cnt_fd", io_readdata, 8'hFD);
    cyc(); chk("cnt_fe", io_readdata, 8'hFE); chk("irq_before_ovf", {7'd0, irq}, 8'h00);
    cyc(); chk("cnt_ff", io_readdata, 8'hFF); chk("irq_ovf", {7'd0, irq}, 8'h01);
    cyc(); chk("cnt_reload", io_readdata, 8'h10);
    wr(5'h00, 8'h00); wr(5'h04, 8'h03);
    wr(5'h01, 8'hFF); wr(5'h00, 8'h23);
    repeat (4) cyc();
    io_readaddr = 5'h00; cyc(); chk("oneshot_tcon", io_readdata, 8'h22);
    io_readaddr = 5'h01; cyc(); chk("oneshot_cnt", io_readdata, 8'h10);
    cyc(); chk("oneshot_hold", io_readdata, 8'h10);
    io_readaddr = 5'h04; cyc(); chk("oneshot_stat", io_readdata, 8'h01);
    wr(5'h04, 8'hFF);
    wr(5'h03, 8'h08); wr(5'h01, 8'h07); wr(5'h00, 8'h09);
    chk("cmp_irq_pre", {7'd0, irq}, 8'h00);
    cyc(); chk("cmp_irq", {7'd0, irq}, 8'h01);
    wr(5'h04, 8'h02); chk("cmp_w1c", {7'd0, irq}, 8'h00);
    wr(5'h00, 8'h00); wr(5'h01, 8'h07); wr(5'h00, 8'h09); wr(5'h04, 8'h02);
    chk("cmp_race_irq", {7'd0, irq}, 8'h01);
    io_readaddr = 5'h04; cyc(); chk("cmp_race_stat", io_readdata, 8'h02);
    wr(5'h04, 8'hFF);
    wr(5'h00, 8'h01); wr(5'h01, 8'h40);
    io_readaddr = 5'h01;
    cyc(); chk("collide_40", io_readdata, 8'h40);
    cyc(); chk("collide_41", io_readdata, 8'h41);
    cyc(); c0 = io_readdata;
    pause = 1; io_write_en = 1; io_writeaddr = 5'h03; io_writedata = 8'h77; io_readaddr = 5'h03;
    repeat (3) cyc();
    chk("pause_frozen", io_readdata, c0);
    pause = 0; io_write_en = 0; io_readaddr = 5'h01;
    cyc(); chk("pause_counts", io_readdata, c0 + 8'd4);
    io_readaddr = 5'h03; cyc(); chk("pause_no_write", io_readdata, 8'h08);
    wr(5'h00, 8'h0D); wr(5'h01, 8'hFF);
    io_readaddr = 5'h01;
    cyc(); chk("pre_rst_irq", {7'd0, irq}, 8'h01); chk("pre_rst_rd", io_readdata, 8'hFF);
    #2 reset = 0;
    #1 chk("async_rd", io_readdata, 8'h00); chk("async_irq", {7'd0, irq}, 8'h00);
    repeat (2) cyc();
    reset = 1;
    cyc(); chk("post_rst_cnt", io_readdata, 8'h00);
    io_readaddr = 5'h00; cyc(); chk("post_rst_tcon", io_readdata, 8'h00);
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
